// File: rtl/seq_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_serializer_if
//   Bundles the word-side handshake and the serial-side outputs of
//   seq_serializer so a producer and the serializer share one connection.
//
//   wordIn     producer -> serializer  parallel word
//   wordValid  producer -> serializer  wordIn is valid
//   wordReady  serializer -> producer  holding buffer can accept a word
//   seqOut     serializer -> consumer  serial bit (IDLE_BIT between words)
//   seqValid   serializer -> consumer  seqOut carries a data bit
//   busy       serializer -> consumer  shifter active or holding buffer full
//
//   Modports: master = word producer / observer, slave = serializer.
// -----------------------------------------------------------------------------
interface seq_serializer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] wordIn;
  logic             wordValid;
  logic             wordReady;
  logic             seqOut;
  logic             seqValid;
  logic             busy;

  modport master (
    output wordIn,
    output wordValid,
    input  wordReady,
    input  seqOut,
    input  seqValid,
    input  busy
  );

  modport slave (
    input  wordIn,
    input  wordValid,
    output wordReady,
    output seqOut,
    output seqValid,
    output busy
  );
endinterface

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//   Parallel-to-serial front end for the sequence detector. Accepts WIDTH-bit
//   words over a valid/ready handshake and emits them one bit per clock on
//   seqOut. A one-entry holding buffer lets back-to-back words stream with no
//   idle bit between them. Between words seqOut carries IDLE_BIT and
//   seqValid is low.
//
//   Parameters
//     WIDTH      word width in bits (>= 1)
//     MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//     IDLE_BIT   level driven on seqOut while no word is being shifted
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   seq_serializer_if.slave: wordIn/wordValid/wordReady handshake,
//           registered seqOut/seqValid, and busy
// -----------------------------------------------------------------------------
module seq_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  seq_serializer_if.slave bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Bit that is presented on the line for the word currently in the shifter.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Move the next bit into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Control state (reset)
  logic [0:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q,     ready_d;
  logic             seq_out_q,   seq_out_d;
  logic             seq_valid_q, seq_valid_d;

  // Data state (no reset; meaningless unless the matching control bit is set)
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q,  hold_d;

  logic             is_shift;
  logic             last_bit;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_src;
  logic [WIDTH-1:0] shift_next;

  always_comb begin
    is_shift   = (state_q == ST_SHIFT);
    last_bit   = is_shift && (cnt_q == CNT_LAST);
    // ready_q mirrors !hold_full_q, so an accept never coincides with a drain
    accept     = bus.wordValid && ready_q;
    load       = (!is_shift || last_bit) && (hold_full_q || accept);
    load_src   = hold_full_q ? hold_q : bus.wordIn;
    shift_next = advance(shift_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    seq_out_d   = seq_out_q;
    shift_d     = shift_q;
    hold_d      = hold_q;

    if (load) begin
      shift_d   = load_src;
      cnt_d     = '0;
      state_d   = ST_SHIFT;
      seq_out_d = head_bit(load_src);
      if (hold_full_q) begin
        hold_full_d = 1'b0;
      end
    end else if (last_bit) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      seq_out_d = IDLE_BIT;
    end else if (is_shift) begin
      shift_d   = shift_next;
      cnt_d     = cnt_q + CNT_W'(1);
      seq_out_d = head_bit(shift_next);
    end

    // A word that could not go straight into the shifter parks in the hold.
    if (accept && !(load && !hold_full_q)) begin
      hold_d      = bus.wordIn;
      hold_full_d = 1'b1;
    end

    seq_valid_d = (state_d == ST_SHIFT);
    ready_d     = !hold_full_d;
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      seq_out_q   <= IDLE_BIT;
      seq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      seq_out_q   <= seq_out_d;
      seq_valid_q <= seq_valid_d;
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  assign bus.wordReady = ready_q;
  assign bus.seqOut    = seq_out_q;
  assign bus.seqValid  = seq_valid_q;
  assign bus.busy      = (state_q == ST_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
//   Directed bench for seq_serializer: an MSB-first 8-bit instance, an
//   LSB-first 8-bit instance and a 1-bit instance share clock and reset.
// -----------------------------------------------------------------------------
module tb_seq_serializer;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  seq_serializer_if #(.WIDTH(8)) m_if ();
  seq_serializer_if #(.WIDTH(8)) l_if ();
  seq_serializer_if #(.WIDTH(1)) w_if ();

  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bus(m_if.slave)
  );
  seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(l_if.slave)
  );
  seq_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .bus(w_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sporadic-stream scoreboard state
  logic [7:0] exp_q[$];
  int         n_rx;
  int         cyc;
  int         nb;
  int         gap;
  int         wt;
  logic [7:0] acc;
  logic [7:0] word;

  // Detector model state
  logic [3:0] sr;
  int         nbits;
  int         nflag;
  int         flag_pos[4];

  logic [15:0] exp16;
  logic [7:0]  exp8;
  logic [4:0]  bits5;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    m_if.wordIn = '0; m_if.wordValid = 1'b0;
    l_if.wordIn = '0; l_if.wordValid = 1'b0;
    w_if.wordIn = '0; w_if.wordValid = 1'b0;

    // ---------------- power-on reset ----------------
    #2 rst = 1'b1;
    #1;
    check("por_valid", m_if.seqValid, 1'b0);
    check("por_out",   m_if.seqOut,   1'b0);
    check("por_ready", m_if.wordReady, 1'b0);
    check("por_busy",  m_if.busy,     1'b0);
    check("por_ready_lsb", l_if.wordReady, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("por_ready_after", m_if.wordReady, 1'b1);
    check("por_ready_after_lsb", l_if.wordReady, 1'b1);
    check("por_ready_after_w1", w_if.wordReady, 1'b1);

    // ---------------- single word 8'h90, MSB first ----------------
    exp8 = 8'h90;
    m_if.wordIn = exp8;
    m_if.wordValid = 1'b1;
    tick();
    m_if.wordValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("single_bit",   m_if.seqOut,   exp8[7-i]);
      check("single_valid", m_if.seqValid, 1'b1);
      tick();
    end
    check("single_end_valid", m_if.seqValid, 1'b0);
    check("single_end_out",   m_if.seqOut,   1'b0);
    check("single_end_busy",  m_if.busy,     1'b0);

    // ---------------- back-to-back 8'hA5, 8'h3C ----------------
    exp16 = 16'hA53C;
    m_if.wordIn = 8'hA5;
    m_if.wordValid = 1'b1;
    tick();
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) m_if.wordIn = 8'h3C;
      if (k == 1) m_if.wordValid = 1'b0;
      if (k < 16) begin
        check("b2b_bit",   m_if.seqOut,   exp16[15-k]);
        check("b2b_valid", m_if.seqValid, 1'b1);
      end else begin
        check("b2b_end_valid", m_if.seqValid, 1'b0);
        check("b2b_end_out",   m_if.seqOut,   1'b0);
      end
      check("b2b_ready", m_if.wordReady, (k >= 1 && k <= 7) ? 1'b0 : 1'b1);
      tick();
    end

    // ---------------- reset mid-word with the hold full ----------------
    m_if.wordIn = 8'hA5;
    m_if.wordValid = 1'b1;
    tick();
    m_if.wordIn = 8'hFF;
    tick();
    m_if.wordValid = 1'b0;
    check("rst_pre_ready", m_if.wordReady, 1'b0);
    check("rst_pre_busy",  m_if.busy,      1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_now_valid", m_if.seqValid,  1'b0);
    check("rst_now_out",   m_if.seqOut,    1'b0);
    check("rst_now_ready", m_if.wordReady, 1'b0);
    check("rst_now_busy",  m_if.busy,      1'b0);
    tick();
    tick();
    check("rst_hold_ready", m_if.wordReady, 1'b0);
    rst = 1'b0;
    tick();
    check("rst_rel_ready", m_if.wordReady, 1'b1);
    check("rst_rel_busy",  m_if.busy,      1'b0);
    for (int k = 0; k < 12; k++) begin
      check("rst_no_stale_valid", m_if.seqValid, 1'b0);
      check("rst_no_stale_out",   m_if.seqOut,   1'b0);
      tick();
    end

    // ---------------- LSB first, 8'h01 ----------------
    exp8 = 8'h01;
    l_if.wordIn = exp8;
    l_if.wordValid = 1'b1;
    tick();
    l_if.wordValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit",   l_if.seqOut,   exp8[i]);
      check("lsb_valid", l_if.seqValid, 1'b1);
      tick();
    end
    check("lsb_end_valid", l_if.seqValid, 1'b0);

    // ---------------- WIDTH=1 continuous stream ----------------
    bits5 = 5'b10110;
    w_if.wordIn = bits5[4];
    w_if.wordValid = 1'b1;
    tick();
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) w_if.wordIn = bits5[3-k];
      if (k == 4) w_if.wordValid = 1'b0;
      if (k < 5) begin
        check("w1_bit",   w_if.seqOut,   bits5[4-k]);
        check("w1_valid", w_if.seqValid, 1'b1);
      end else begin
        check("w1_end_valid", w_if.seqValid, 1'b0);
      end
      tick();
    end

    // ---------------- sporadic stream, 1000 random words ----------------
    n_rx = 0;
    cyc  = 0;
    nb   = 0;
    acc  = '0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) tick();
          word = 8'($urandom);
          m_if.wordIn = word;
          m_if.wordValid = 1'b1;
          wt = 0;
          while (!m_if.wordReady && wt < 50) begin
            tick();
            wt++;
          end
          if (wt >= 50) check("spor_ready_timeout", wt, 0);
          exp_q.push_back(word);
          tick();
          m_if.wordValid = 1'b0;
        end
      end
      begin
        while (n_rx < 1000 && cyc < 30000) begin
          tick();
          cyc++;
          if (m_if.seqValid) begin
            acc = {acc[6:0], m_if.seqOut};
            nb++;
            if (nb == 8) begin
              nb = 0;
              if (exp_q.size() == 0) check("spor_extra_word", 1, 0);
              else check("spor_word", acc, exp_q.pop_front());
              n_rx++;
            end
          end else begin
            check("spor_gap_out", m_if.seqOut, 1'b0);
          end
        end
        check("spor_count", n_rx, 1000);
      end
    join
    check("spor_leftover", exp_q.size(), 0);
    tick();
    tick();

    // ---------------- chained with a 1001 detector model ----------------
    sr = '0;
    nbits = 0;
    nflag = 0;
    m_if.wordIn = 8'h99;
    m_if.wordValid = 1'b1;
    tick();
    m_if.wordValid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (m_if.seqValid) begin
        sr = {sr[2:0], m_if.seqOut};
        if (nbits >= 3 && sr == 4'b1001 && nflag < 4) begin
          flag_pos[nflag] = nbits;
          nflag++;
        end
        nbits++;
      end
      tick();
    end
    check("det_nbits", nbits, 8);
    check("det_nflag", nflag, 2);
    check("det_pos0",  flag_pos[0], 3);
    check("det_pos1",  flag_pos[1], 7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
